// File: rtl/muldiv_pkg.sv
// Shared constants, op codes and FSM state encoding for the multiply/divide unit.
// Pure definitions, no logic or latency of its own.
// No handshake; imported by muldiv_unit and div_step.
package muldiv_pkg;

    localparam int WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Divide-by-zero quotient: all ones for both signed and unsigned divides.
    localparam logic [WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF;

    // Final value of the iteration counter (32 iterations, counted 0..31).
    localparam logic [5:0] LAST_ITER = 6'd31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_e;

    // Two's-complement negation, wrapping (so -0x8000_0000 stays 0x8000_0000).
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + WIDTH'(1);
    endfunction

    // Absolute value when neg is set, pass-through otherwise.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? negate(v) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration, or one shift-add multiply accumulate step when mul_i is set.
// Latency: purely combinational.
// No handshake; the caller registers rem_o/q_o every iteration.
module div_step
    import muldiv_pkg::*;
(
    input  logic             mul_i,
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] sum;

    // Divide: shift in the next dividend bit and subtract the divisor if it fits.
    // Multiply: add the multiplicand when the multiplier bit is set; q_o is the carry out.
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {1'b0, opb_i};
        sum     = {1'b0, rem_i} + {1'b0, (bit_i ? opb_i : '0)};
        if (mul_i) begin
            rem_o = sum[WIDTH-1:0];
            q_o   = sum[WIDTH];
        end else begin
            // rem_i < divisor, so a non-borrowing difference always fits in WIDTH bits.
            q_o   = ~diff[WIDTH];
            rem_o = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO register; optional macro MULDIV_ITER_MUL_EN.
// Latency: divide 34 cycles, multiply 3 cycles (34 with MULDIV_ITER_MUL_EN), divide-by-zero 1 cycle.
// Backpressure: none; busy_o stalls the pipeline, start_i is ignored while busy, cancel_i aborts.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             hilo_we_o
);

    state_e           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    // work_hi: partial remainder / product high; work_lo: dividend->quotient / multiplier->product low
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             is_signed_q;
    logic             step_mul;
    logic             step_bit;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;
    logic [2*WIDTH-1:0] mag_prod;
    logic             accept_signed;

    assign is_signed_q   = ~op_q[0];
    assign accept_signed = ~op_i[0];

`ifdef MULDIV_ITER_MUL_EN
    // Shared datapath: multiply consumes the multiplier LSB first, divide the dividend MSB first.
    assign step_mul = ~op_q[1];
    assign step_bit = op_q[1] ? work_lo_q[WIDTH-1] : work_lo_q[0];
`else
    logic [2*WIDTH-1:0] prod;

    assign step_mul = 1'b0;
    assign step_bit = work_lo_q[WIDTH-1];
    assign prod     = {{WIDTH{1'b0}}, work_lo_q} * {{WIDTH{1'b0}}, opb_q};
`endif

    div_step u_div_step (
        .mul_i (step_mul),
        .rem_i (work_hi_q),
        .bit_i (step_bit),
        .opb_i (opb_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // Sign correction of the magnitude result: quotient/product follow sign XOR, remainder the dividend.
    always_comb begin
        fix_hi   = work_hi_q;
        fix_lo   = work_lo_q;
        mag_prod = {work_hi_q, work_lo_q};
        if (!op_q[1]) begin
            if (is_signed_q && (sign_a_q ^ sign_b_q)) begin
                {fix_hi, fix_lo} = (~mag_prod) + {{(2*WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            if (is_signed_q && (sign_a_q ^ sign_b_q)) begin
                fix_lo = negate(work_lo_q);
            end
            if (is_signed_q && sign_a_q) begin
                fix_hi = negate(work_hi_q);
            end
        end
    end

    // Next-state and datapath updates; cancel wins over everything outside IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        if (state_q != ST_IDLE && cancel_i) begin
            // Abort without touching the architectural result registers.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !cancel_i) begin
                        op_d      = op_i;
                        sign_a_d  = a_i[WIDTH-1];
                        sign_b_d  = b_i[WIDTH-1];
                        work_hi_d = '0;
                        work_lo_d = magnitude(a_i, accept_signed & a_i[WIDTH-1]);
                        opb_d     = magnitude(b_i, accept_signed & b_i[WIDTH-1]);
                        if (op_i[1] && (b_i == '0)) begin
                            // Divide by zero resolves immediately with a fixed result.
                            state_d = ST_DONE;
                            hi_d    = a_i;
                            lo_d    = DIV0_LO;
                        end else begin
                            state_d = ST_CALC;
`ifdef MULDIV_ITER_MUL_EN
                            cnt_d   = '0;
`else
                            cnt_d   = op_i[1] ? 6'd0 : LAST_ITER;
`endif
                        end
                    end
                end

                ST_CALC: begin
                    if (op_q[1]) begin
                        work_hi_d = step_rem;
                        work_lo_d = {work_lo_q[WIDTH-2:0], step_q};
                    end else begin
`ifdef MULDIV_ITER_MUL_EN
                        // Shift the accumulator right, carry entering at the top.
                        work_hi_d = {step_q, step_rem[WIDTH-1:1]};
                        work_lo_d = {step_rem[0], work_lo_q[WIDTH-1:1]};
`else
                        {work_hi_d, work_lo_d} = prod;
`endif
                    end
                    if (cnt_q == LAST_ITER) begin
                        state_d = ST_FIX;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 6'd1;
                    end
                end

                ST_FIX: begin
                    hi_d    = fix_hi;
                    lo_d    = fix_lo;
                    state_d = ST_DONE;
                end

                ST_DONE: begin
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, working and result registers; reset clears everything.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_MULT;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy_o    = (state_q != ST_IDLE);
    // A flush arriving in the DONE cycle must still block the HI/LO write.
    assign hilo_we_o = (state_q == ST_DONE) && !cancel_i;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops against an arithmetic model.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Compile with MULDIV_ITER_MUL_EN defined to check the iterative-multiply latency.
module tb_muldiv_unit;

    localparam int M_NORM        = 0;
    localparam int M_NOISE       = 1;
    localparam int M_CANCEL_MID  = 2;
    localparam int M_CANCEL_DONE = 3;

`ifdef MULDIV_ITER_MUL_EN
    localparam int MUL_LAT = 34;
`else
    localparam int MUL_LAT = 3;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        hilo_we;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    muldiv_unit dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .start_i   (start),
        .op_i      (op),
        .a_i       (a),
        .b_i       (b),
        .cancel_i  (cancel),
        .busy_o    (busy),
        .hi_o      (hi),
        .lo_o      (lo),
        .hilo_we_o (hilo_we)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural result {hi, lo} straight from the instruction definitions.
    function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb);
        longint      sa, sb, q, m;
        logic [63:0] ua, ub, r;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        ua = {32'h0, ma};
        ub = {32'h0, mb};
        r  = '0;
        case (mop)
            2'b00: r = sa * sb;
            2'b01: r = ua * ub;
            default: begin
                if (mb == 32'h0) begin
                    r = {ma, 32'hFFFF_FFFF};
                end else if (mop == 2'b10) begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end else begin
                    q = longint'(ua / ub);
                    m = longint'(ua % ub);
                    r = {m[31:0], q[31:0]};
                end
            end
        endcase
        return r;
    endfunction

    // Cycle (counted after the accepting edge) in which hilo_we is expected.
    function automatic int latency(input logic [1:0] lop, input logic [31:0] lb);
        if (!lop[1]) return MUL_LAT;
        if (lb == 32'h0) return 1;
        return 34;
    endfunction

    task automatic run_op(input int mode, input logic [1:0] top, input logic [31:0] ta,
                          input logic [31:0] tb, input logic [63:0] exp);
        int   lat;
        int   we_cnt;
        int   we_cyc;
        logic exp_busy;
        lat    = latency(top, tb);
        we_cnt = 0;
        we_cyc = 0;
        start  = 1'b1;
        op     = top;
        a      = ta;
        b      = tb;
        step();
        start  = 1'b0;
        op     = 2'($urandom);
        a      = $urandom;
        b      = $urandom;
        for (int k = 1; k <= lat + 1; k++) begin
            exp_busy = (mode == M_CANCEL_MID) ? (k <= 10) : (k <= lat);
            check("busy", 64'(busy), 64'(exp_busy));
            if (mode == M_CANCEL_DONE && k == lat) begin
                cancel = 1'b1;
                #1;
                check("we_under_cancel", 64'(hilo_we), 64'(0));
            end
            if (hilo_we === 1'b1) begin
                we_cnt++;
                we_cyc = k;
            end
            if (k == lat && mode <= M_NOISE) begin
                check("hi", 64'(hi), 64'(exp[63:32]));
                check("lo", 64'(lo), 64'(exp[31:0]));
            end
            if (mode == M_NOISE) begin
                start = (k >= 2 && k <= lat);
                op    = 2'($urandom);
                a     = $urandom;
                b     = $urandom;
            end
            if (mode == M_CANCEL_MID) cancel = (k == 10);
            if (mode == M_CANCEL_DONE) cancel = (k == lat);
            step();
        end
        cancel = 1'b0;
        start  = 1'b0;
        check("we_count", 64'(we_cnt), (mode >= M_CANCEL_MID) ? 64'(0) : 64'(1));
        if (mode <= M_NOISE) check("we_cycle", 64'(we_cyc), 64'(lat));
        if (mode == M_CANCEL_MID) begin
            check("hi_hold", 64'(hi), 64'(prev_hi));
            check("lo_hold", 64'(lo), 64'(prev_lo));
        end else begin
            prev_hi = exp[63:32];
            prev_lo = exp[31:0];
        end
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;

        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        a       = '0;
        b       = '0;
        cancel  = 1'b0;
        prev_hi = '0;
        prev_lo = '0;
        step();
        step();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_we", 64'(hilo_we), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        rst_n = 1'b1;
        step();
        check("idle_busy", 64'(busy), 64'(0));

        // Directed cases
        run_op(M_NORM, 2'b11, 32'd100, 32'd7, {32'd2, 32'd14});
        run_op(M_NORM, 2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(M_NORM, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
        run_op(M_NORM, 2'b00, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        run_op(M_NORM, 2'b01, 32'hFFFF_FFFF, 32'd2, {32'h1, 32'hFFFF_FFFE});
        run_op(M_NORM, 2'b11, 32'h1234, 32'h0, {32'h1234, 32'hFFFF_FFFF});
        run_op(M_NORM, 2'b10, 32'hFFFF_FF00, 32'h0, {32'hFFFF_FF00, 32'hFFFF_FFFF});
        run_op(M_NORM, 2'b10, 32'd1000, 32'hFFFF_FFFD, {32'h1, 32'hFFFF_FEB3});

        // Cancel mid-divide keeps the previous result
        run_op(M_CANCEL_MID, 2'b10, 32'd12345, 32'd17, model(2'b10, 32'd12345, 32'd17));

        // Cancel coincident with DONE blocks the write strobe
        run_op(M_CANCEL_DONE, 2'b11, 32'd50, 32'd5, model(2'b11, 32'd50, 32'd5));

        // Start held high while busy must be ignored
        run_op(M_NOISE, 2'b11, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF});
        run_op(M_NOISE, 2'b00, 32'd7, 32'hFFFF_FFFA, {32'hFFFF_FFFF, 32'hFFFF_FFD6});

        // Reset in the middle of a divide clears outputs immediately
        start = 1'b1;
        op    = 2'b10;
        a     = 32'd99999;
        b     = 32'd13;
        step();
        start = 1'b0;
        repeat (9) step();
        check("pre_reset_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_we", 64'(hilo_we), 64'(0));
        check("mid_rst_hi", 64'(hi), 64'(0));
        check("mid_rst_lo", 64'(lo), 64'(0));
        step();
        rst_n   = 1'b1;
        prev_hi = '0;
        prev_lo = '0;
        step();
        check("post_rst_busy", 64'(busy), 64'(0));
        run_op(M_NORM, 2'b10, 32'hFFFF_0000, 32'd3, model(2'b10, 32'hFFFF_0000, 32'd3));

        // Randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            sel = $urandom_range(0, 5);
            case (sel)
                0:       rb = 32'h0;
                1:       rb = $urandom_range(1, 255);
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) ra = 32'h8000_0000;
            run_op(M_NORM, rop, ra, rb, model(rop, ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
